instr_memory: RTL and testbench

- Read-only instruction memory for the fetch stage of the ARM pipeline.
- Takes the 64-bit program counter and returns the 32-bit instruction word stored at that byte address.
- Registered read: the instruction appears one rising clock edge after the PC is presented.
- The bench clock comes from the shared oscillator block (period `CYCLE, first rising edge at `CYCLE/2). The oscillator is not part of this block.

---
 rtl/instr_memory.sv | 67 ++++++
 tb/tb_instr_memory.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instr_memory.sv
// instr_memory: registered read-only instruction ROM for the fetch stage (word = mem[pc >> 2]).
// The image is the built-in cyclic pattern computed at elaboration for any SIZE.
`timescale 1ns/1ps
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_memory #(
  parameter int SIZE = 64
`ifdef INSTR_MEM_INIT_FILE_EN
  , parameter string INIT_FILE = "instr.mem"
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [`WORD-1:0]      pc,
  output logic [`INSTR_LEN-1:0] instruction
);

  localparam int          DEPTH   = SIZE / 4;
  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH32 = DEPTH;

  logic [`INSTR_LEN-1:0] mem [DEPTH];
  logic [`WORD-3:0]      word_addr;
  logic [`WORD-3:0]      depth_addr;
  logic                  in_range;
  logic                  unused_byte_offset;

  // The full word address is range-checked so nonzero upper PC bits never alias into the array.
  assign word_addr          = pc[`WORD-1:2];
  assign depth_addr         = {{(`WORD-34){1'b0}}, DEPTH32};
  assign in_range           = (word_addr < depth_addr);
  assign unused_byte_offset = ^pc[1:0];

  // Word k is 8 hex digits of the cyclic string "ABCDEF123456789" starting at digit k mod 15.
  function automatic logic [`INSTR_LEN-1:0] pattern_word(input int k);
    logic [`INSTR_LEN-1:0] w;
    int                    p;
    w = '0;
    for (int i = 0; i < `INSTR_LEN / 4; i++) begin
      p = (k + i) % 15;
      w = {w[`INSTR_LEN-5:0], (p < 6) ? 4'(p + 10) : 4'(p - 5)};
    end
    return w;
  endfunction

  for (genvar k = 0; k < DEPTH; k++) begin : g_image
    assign mem[k] = pattern_word(k);
  end

  // NOTE: the ROM array is never reset; only the output register clears, so contents survive rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= '0;
    end else if (in_range) begin
      // NOTE: non-blocking assignment keeps the read registered with exactly one edge of latency.
      instruction <= mem[word_addr[IDX_W-1:0]];
    end else begin
      instruction <= '0;
    end
  end

endmodule

// File: tb/tb_instr_memory.sv
// tb_instr_memory: directed and random checks of instr_memory against a string-based reference model.
// Built-in pattern image only (INSTR_MEM_INIT_FILE_EN undefined).
`timescale 1ns/1ps
`ifndef CYCLE
`define CYCLE 10
`endif

module tb_instr_memory;

  localparam int SIZE = 64;

  logic        clk;
  logic        rst_n;
  logic [63:0] pc;
  logic [31:0] instruction;

  int errors = 0;
  int checks = 0;

  instr_memory #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .instruction (instruction)
  );

  initial begin
    clk = 1'b0;
    forever #(`CYCLE / 2) clk = ~clk;
  end

  // Expected word: read 8 characters of the hex string and convert them digit by digit.
  function automatic logic [31:0] ref_word(input logic [63:0] addr);
    string           s;
    logic [31:0]     w;
    logic [63:0]     idx;
    logic [7:0]      c;
    int              d;
    int              j;
    s   = "ABCDEF123456789";
    w   = '0;
    idx = addr >> 2;
    if (idx >= 64'(SIZE / 4)) return 32'h0;
    for (int i = 0; i < 8; i++) begin
      j = int'((idx + 64'(i)) % 64'd15);
      c = s[j];
      d = (c >= 8'h41) ? (int'(c) - 'h41 + 10) : (int'(c) - 'h30);
      w = {w[27:0], d[3:0]};
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present a PC just after an edge, then sample just after the following edge.
  task automatic fetch(input logic [63:0] addr, input string tag);
    pc = addr;
    @(posedge clk);
    #1;
    check(tag, instruction, ref_word(addr));
  endtask

  initial begin
    logic [63:0] raddr;

    rst_n = 1'b0;
    pc    = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_zero", instruction, 32'h0000_0000);

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", instruction, 32'hABCDEF12);

    fetch(64'd0, "pc0");
    check("pc0_const", instruction, 32'hABCDEF12);
    fetch(64'd4, "pc4");
    check("pc4_const", instruction, 32'hBCDEF123);
    fetch(64'd8, "pc8");
    check("pc8_const", instruction, 32'hCDEF1234);

    pc = 64'd12;
    @(negedge clk);
    check("hold_before_edge", instruction, 32'hCDEF1234);
    @(posedge clk);
    #1;
    check("pc12_after_edge", instruction, 32'hDEF12345);
    fetch(64'd16, "pc16");
    check("pc16_const", instruction, 32'hEF123456);

    fetch(64'd52, "pc52");
    check("pc52_const", instruction, 32'h89ABCDEF);
    fetch(64'd56, "pc56");
    check("pc56_const", instruction, 32'h9ABCDEF1);
    fetch(64'd28, "pc28");
    check("pc28_const", instruction, 32'h23456789);
    fetch(64'd60, "pc60");
    check("pc60_const", instruction, 32'hABCDEF12);

    fetch(64'd13, "pc13_unaligned");
    check("pc13_const", instruction, 32'hDEF12345);
    fetch(64'd64, "pc64_oor");
    check("pc64_const", instruction, 32'h0000_0000);
    fetch(64'd63, "pc63_last");
    check("pc63_const", instruction, 32'hABCDEF12);
    fetch(64'h1_0000_0000, "pc_upper_oor");
    check("pc_upper_const", instruction, 32'h0000_0000);
    fetch(64'h8000_0000_0000_0004, "pc_msb_oor");

    fetch(64'd16, "pre_async_reset");
    check("pre_async_const", instruction, 32'hEF123456);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", instruction, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("reset_hold", instruction, 32'h0000_0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("contents_after_reset", instruction, 32'hEF123456);

    for (int n = 0; n < 200; n++) begin
      if ((n % 8) == 7) raddr = {$urandom, $urandom};
      else              raddr = 64'($urandom_range(0, SIZE + 15));
      fetch(raddr, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
